// File: rtl/enemy_controller_if.sv
// Spawn request handshake between the level sequencer and the enemy table.
// The master drives requests; the slave reports slot availability.
interface enemy_controller_if;
    logic        spawn_valid;
    logic [12:0] spawn_x;
    logic        spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_x,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_x,
        output spawn_ready
    );
endinterface

// File: rtl/enemy_controller.sv
// Enemy table: spawns, patrols, squashes and per-pixel selects goombas.
// Selection is combinational from the registered table, so it has zero latency.
module enemy_controller #(
    parameter int NUM_ENEMIES   = 4,
    parameter int WIDTH         = 16,
    parameter int HEIGHT        = 16,
    parameter int SPEED         = 1,
    parameter int PATROL_W      = 64,
    parameter int ANIM_FRAMES   = 8,
    parameter int SQUASH_FRAMES = 30,
    parameter int GROUND_Y      = 208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [11:0] offset_background,
    input  logic        collision_info,
    enemy_controller_if.slave spawn,
    output logic [12:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  image_index_out,
    output logic        no_enemy_out,
    output logic [2:0]  alive_count
);

    localparam int IW  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int SQW = $clog2(SQUASH_FRAMES + 1);
    localparam int AW  = $clog2(ANIM_FRAMES + 1);

    localparam logic [12:0] X_MAX = 13'(8191 - WIDTH - PATROL_W);
    localparam logic [12:0] SPD   = 13'(SPEED);
    localparam logic [12:0] PW    = 13'(PATROL_W);
    localparam logic [13:0] W14   = 14'(WIDTH);
    localparam logic [10:0] Y_LO  = 11'(GROUND_Y);
    localparam logic [10:0] Y_HI  = 11'(GROUND_Y + HEIGHT);
    localparam logic [SQW-1:0] SQ_INIT = SQW'(SQUASH_FRAMES);
    localparam logic [SQW-1:0] SQ_ONE  = SQW'(1);
    localparam logic [AW-1:0]  A_LAST  = AW'(ANIM_FRAMES - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WALK   = 2'd1,
        SQUASH = 2'd2
    } slot_e;

    slot_e          st_q   [NUM_ENEMIES];
    slot_e          st_d   [NUM_ENEMIES];
    logic [12:0]    x_q    [NUM_ENEMIES];
    logic [12:0]    x_d    [NUM_ENEMIES];
    logic [12:0]    home_q [NUM_ENEMIES];
    logic [12:0]    home_d [NUM_ENEMIES];
    logic           dir_q  [NUM_ENEMIES];
    logic           dir_d  [NUM_ENEMIES];
    logic [SQW-1:0] sq_q   [NUM_ENEMIES];
    logic [SQW-1:0] sq_d   [NUM_ENEMIES];

    logic [AW-1:0] cnt_q, cnt_d;
    logic          anim_q, anim_d;
    logic [2:0]    alive_d;

    logic          tick;
    logic [12:0]   wx;
    logic          v_in;
    logic          hit;
    logic [IW-1:0] sel;
    logic          free_hit;
    logic [IW-1:0] free_idx;
    logic          coll_go;
    logic          spawn_go;
    logic [12:0]   spawn_clamped;
    logic [12:0]   nx;
    logic [12:0]   lim;

    assign tick = (hcount_in == 11'd0) && (vcount_in == 10'd240);
    assign wx   = {2'b00, hcount_in} + {1'b0, offset_background};
    assign v_in = ({1'b0, vcount_in} >= Y_LO) &&
                  ({1'b0, vcount_in} <  Y_HI);

    // Descending scan so the lowest covering index is the last to win.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (st_q[i] != FREE && v_in &&
                ({1'b0, x_q[i]} <= {1'b0, wx}) &&
                ({1'b0, wx} < {1'b0, x_q[i]} + W14)) begin
                hit = 1'b1;
                sel = IW'(i);
            end
        end
    end

    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        alive_d  = 3'd0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (st_q[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
            if (st_q[i] == WALK)
                alive_d = alive_d + 3'd1;
        end
    end

    assign spawn.spawn_ready = free_hit;

    always_comb begin
        x_out           = 13'd0;
        y_out           = 10'd0;
        image_index_out = 2'd0;
        no_enemy_out    = 1'b1;
        if (hit) begin
            no_enemy_out = 1'b0;
            x_out        = x_q[sel];
            y_out        = 10'(GROUND_Y);
            if (st_q[sel] == SQUASH)
                image_index_out = 2'd2;
            else
                image_index_out = {1'b0, anim_q};
        end
    end

    assign coll_go  = collision_info && hit && (st_q[sel] == WALK);
    assign spawn_go = spawn.spawn_valid && free_hit;
    assign spawn_clamped = (spawn.spawn_x > X_MAX) ? X_MAX : spawn.spawn_x;

    always_comb begin
        cnt_d  = cnt_q;
        anim_d = anim_q;
        if (tick) begin
            if (cnt_q == A_LAST) begin
                cnt_d  = '0;
                anim_d = ~anim_q;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        home_d = home_q;
        dir_d  = dir_q;
        sq_d   = sq_q;
        nx     = 13'd0;
        lim    = 13'd0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (coll_go && sel == IW'(i)) begin
                st_d[i] = SQUASH;
                sq_d[i] = SQ_INIT;
            end else if (spawn_go && free_idx == IW'(i)) begin
                st_d[i]   = WALK;
                x_d[i]    = spawn_clamped;
                home_d[i] = spawn_clamped;
                dir_d[i]  = 1'b0;
            end else if (tick) begin
                unique case (st_q[i])
                    WALK: begin
                        nx  = x_q[i] + SPD;
                        lim = home_q[i] + PW;
                        if ({1'b0, x_q[i]} + W14 <=
                            {2'b00, offset_background}) begin
                            st_d[i] = FREE;
                        end else if (!dir_q[i]) begin
                            if (nx >= lim) begin
                                x_d[i]   = lim;
                                dir_d[i] = 1'b1;
                            end else begin
                                x_d[i] = nx;
                            end
                        end else begin
                            // Compare before subtracting to avoid underflow.
                            if ({1'b0, x_q[i]} <=
                                {1'b0, home_q[i]} + {1'b0, SPD}) begin
                                x_d[i]   = home_q[i];
                                dir_d[i] = 1'b0;
                            end else begin
                                x_d[i] = x_q[i] - SPD;
                            end
                        end
                    end
                    SQUASH: begin
                        if (sq_q[i] == SQ_ONE)
                            st_d[i] = FREE;
                        else
                            sq_d[i] = sq_q[i] - SQ_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                st_q[i]   <= FREE;
                x_q[i]    <= 13'd0;
                home_q[i] <= 13'd0;
                dir_q[i]  <= 1'b0;
                sq_q[i]   <= '0;
            end
            cnt_q       <= '0;
            anim_q      <= 1'b0;
            alive_count <= 3'd0;
        end else begin
            st_q        <= st_d;
            x_q         <= x_d;
            home_q      <= home_d;
            dir_q       <= dir_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            anim_q      <= anim_d;
            alive_count <= alive_d;
        end
    end

endmodule

// File: tb/tb_enemy_controller.sv
// Scoreboard bench for enemy_controller: directed probes queue expectations,
// a negedge monitor pops and compares them.
module tb_enemy_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = 11'd1;
    logic [9:0]  vcount = 10'd0;
    logic [11:0] offset = 12'd0;
    logic        collision = 1'b0;
    logic [12:0] x_o;
    logic [9:0]  y_o;
    logic [1:0]  idx_o;
    logic        ne_o;
    logic [2:0]  alive_o;

    enemy_controller_if sif();

    enemy_controller dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .offset_background (offset),
        .collision_info    (collision),
        .spawn             (sif),
        .x_out             (x_o),
        .y_out             (y_o),
        .image_index_out   (idx_o),
        .no_enemy_out      (ne_o),
        .alive_count       (alive_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ne;
        logic [12:0] x;
        logic [9:0]  y;
        logic [1:0]  idx;
        logic [2:0]  alive;
        logic        rdy;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    logic  probe_en = 1'b0;
    int    checks = 0;
    int    failures = 0;
    exp_t  me;
    string mn;

    always @(negedge clk) begin
        if (probe_en) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: probe with no expectation");
            end else begin
                me = q.pop_front();
                mn = nq.pop_front();
                if (ne_o !== me.ne || x_o !== me.x || y_o !== me.y ||
                    idx_o !== me.idx || alive_o !== me.alive ||
                    sif.spawn_ready !== me.rdy) begin
                    failures++;
                    $display("FAIL %s: got ne=%0b x=%0d y=%0d idx=%0d alive=%0d rdy=%0b want ne=%0b x=%0d y=%0d idx=%0d alive=%0d rdy=%0b",
                             mn, ne_o, x_o, y_o, idx_o, alive_o,
                             sif.spawn_ready, me.ne, me.x, me.y,
                             me.idx, me.alive, me.rdy);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic ne,
                        input int x, input int idx,
                        input int alive, input logic rdy);
        exp_t e;
        e.ne    = ne;
        e.x     = 13'(x);
        e.y     = ne ? 10'd0 : 10'd208;
        e.idx   = 2'(idx);
        e.alive = 3'(alive);
        e.rdy   = rdy;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic probe(input string nm, input int h, input logic ne,
                         input int x, input int idx,
                         input int alive, input logic rdy);
        hcount = 11'(h);
        vcount = 10'd208;
        push(nm, ne, x, idx, alive, rdy);
        probe_en = 1'b1;
        cyc();
        probe_en = 1'b0;
        hcount = 11'd1;
        vcount = 10'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            hcount = 11'd0;
            vcount = 10'd240;
            cyc();
            hcount = 11'd1;
            vcount = 10'd0;
        end
    endtask

    task automatic spawn(input int x);
        sif.spawn_valid = 1'b1;
        sif.spawn_x     = 13'(x);
        cyc();
        sif.spawn_valid = 1'b0;
    endtask

    task automatic collide(input int h);
        hcount    = 11'(h);
        vcount    = 10'd208;
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        hcount    = 11'd1;
        vcount    = 10'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.spawn_valid = 1'b0;
        collision = 1'b0;
        offset = 12'd0;
        hcount = 11'd1;
        vcount = 10'd0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        sif.spawn_valid = 1'b0;
        sif.spawn_x     = 13'd0;
        do_reset();

        probe("reset", 100, 1, 0, 0, 0, 1);
        spawn(100);
        probe("alive_lag", 100, 0, 100, 0, 0, 1);
        probe("right_edge", 116, 1, 0, 0, 1, 1);
        probe("last_px", 115, 0, 100, 0, 1, 1);
        probe("left_out", 99, 1, 0, 0, 1, 1);

        ticks(8);
        probe("walk8", 108, 0, 108, 1, 1, 1);
        ticks(56);
        probe("turn_far", 164, 0, 164, 0, 1, 1);
        ticks(1);
        probe("going_left", 163, 0, 163, 0, 1, 1);
        probe("edge_l", 179, 1, 0, 0, 1, 1);
        ticks(63);
        probe("home", 100, 0, 100, 0, 1, 1);
        ticks(1);
        probe("going_right", 101, 0, 101, 0, 1, 1);

        do_reset();
        spawn(100);
        spawn(108);
        cyc();
        probe("priority", 110, 0, 100, 0, 2, 1);
        collide(110);
        cyc();
        probe("squash", 110, 0, 100, 2, 1, 1);
        collide(110);
        cyc();
        probe("sq_ignore", 120, 0, 108, 0, 1, 1);
        ticks(29);
        probe("sq_hold", 110, 0, 100, 2, 1, 1);
        ticks(1);
        probe("sq_free", 110, 1, 0, 0, 1, 1);
        probe("next_win", 140, 0, 138, 1, 1, 1);

        do_reset();
        spawn(100);
        spawn(200);
        spawn(300);
        spawn(400);
        spawn(500);
        probe("drop5", 500, 1, 0, 0, 4, 0);
        collide(300);
        cyc();
        probe("sq4", 300, 0, 300, 2, 3, 0);
        ticks(29);
        probe("still_full", 300, 0, 300, 2, 3, 0);
        ticks(1);
        cyc();
        probe("slot_back", 430, 0, 430, 1, 3, 1);

        do_reset();
        spawn(100);
        offset = 12'd115;
        ticks(1);
        probe("edge_keep", 0, 0, 101, 0, 1, 1);
        offset = 12'd117;
        ticks(1);
        cyc();
        probe("despawn", 0, 1, 0, 0, 0, 1);
        offset = 12'd0;

        do_reset();
        spawn(100);
        spawn(200);
        spawn(300);
        cyc();
        probe("three", 200, 0, 200, 0, 3, 1);
        hcount = 11'd200;
        vcount = 10'd208;
        #2;
        rst = 1'b1;
        push("async_rst", 1, 0, 0, 0, 1);
        probe_en = 1'b1;
        cyc();
        probe_en = 1'b0;
        cyc();
        rst = 1'b0;
        hcount = 11'd1;
        vcount = 10'd0;
        cyc();
        probe("post_rst", 200, 1, 0, 0, 0, 1);
        spawn(100);
        ticks(1);
        probe("post_tick", 101, 0, 101, 0, 1, 1);

        cyc();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover: %0d expectations unchecked, want 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
